// File: rtl/vio_serial_adder_pkg.sv
// Shared types and constants for the VIO-driven bit-serial adder.
package vio_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder used as the serial datapath slice.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/vio_serial_adder.sv
// Bit-serial adder: captures operands on a start rising edge, adds LSB-first over WIDTH cycles.
// Optional subtract mode (sub_i port) is built when VIO_SERIAL_SUB_EN is defined.
module vio_serial_adder
    import vio_serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             start_i,
`ifdef VIO_SERIAL_SUB_EN
    input  logic             sub_i,
`endif
    output logic [WIDTH:0]   sum_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cyc_o
);

    state_t           state;
    logic             start_q;
    logic             launch;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             fa_b;
    logic             fa_s;
    logic             fa_co;

    assign launch = start_i & ~start_q;

`ifdef VIO_SERIAL_SUB_EN
    logic sub_q;
    // Subtraction is A + ~B + 1: invert B into the adder, carry-in seeded at launch.
    assign fa_b = b_sh[0] ^ sub_q;
`else
    assign fa_b = b_sh[0];
`endif

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (fa_b),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b1;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            sum_o   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            cyc_o   <= '0;
`ifdef VIO_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            start_q <= start_i;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i;
                        res    <= '0;
                        cyc_o  <= '0;
                        busy_o <= 1'b1;
                        done_o <= 1'b0;
                        state  <= ST_SHIFT;
`ifdef VIO_SERIAL_SUB_EN
                        sub_q  <= sub_i;
                        carry  <= sub_i;
`else
                        carry  <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (cyc_o == CNT_W'(WIDTH)) begin
                        sum_o  <= {carry, res};
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        // Result enters at the MSB so after WIDTH shifts bit 0 lands at res[0].
                        res   <= {fa_s, res[WIDTH-1:1]};
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        carry <= fa_co;
                        cyc_o <= cyc_o + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vio_serial_adder.sv
// Randomized scoreboard bench for vio_serial_adder; expected results come from plain arithmetic.
module tb_vio_serial_adder;

    localparam int W     = 4;
    localparam int CNT_W = $clog2(W + 1);

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   a_i;
    logic [W-1:0]   b_i;
    logic           start;
`ifdef VIO_SERIAL_SUB_EN
    logic           sub;
`endif
    logic [W:0]     sum_o;
    logic           busy_o;
    logic           done_o;
    logic [CNT_W-1:0] cyc_o;

    vio_serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_i     (a_i),
        .b_i     (b_i),
        .start_i (start),
`ifdef VIO_SERIAL_SUB_EN
        .sub_i   (sub),
`endif
        .sum_o   (sum_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .cyc_o   (cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] sum;
        int         ledge;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   cur_l = -1000;
    int   free_at = 0;
    logic start_seen = 1'b1;
    logic rst_seen = 1'b0;
    logic done_prev = 1'b0;
    logic [W:0] last_sum = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [W:0] model(input int a, input int b, input logic s);
        int r;
        r = s ? (a + (1 << W) - b) : (a + b);
        return (W+1)'(r);
    endfunction

    // Edge counter and what the design saw at each edge.
    always @(posedge clk) begin
        cycle++;
        rst_seen   = rst_n;
        start_seen = rst_n ? start : 1'b1;
    end

    // Monitor: samples 1 time unit after every edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst_seen) begin
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_sum",  32'(sum_o),  32'd0);
            chk("rst_cyc",  32'(cyc_o),  32'd0);
            last_sum = '0;
        end else begin
            chk("busy", 32'(busy_o), 32'(cycle >= cur_l && cycle <= cur_l + W));
            if (done_o && !done_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got sum %0d expected no completion", sum_o);
                end else begin
                    e = q.pop_front();
                    chk("sum",     32'(sum_o), 32'(e.sum));
                    chk("cyc",     32'(cyc_o), 32'(W));
                    chk("latency", 32'(cycle - e.ledge), 32'(W + 1));
                end
                last_sum = sum_o;
            end else begin
                chk("sum_hold", 32'(sum_o), 32'(last_sum));
            end
        end
        done_prev = done_o;
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
        logic eff_s;
        exp_t e;
        @(negedge clk);
        a_i   = a;
        b_i   = b;
        start = 1'b1;
`ifdef VIO_SERIAL_SUB_EN
        sub   = s;
        eff_s = s;
`else
        eff_s = 1'b0 & s;
`endif
        if (!start_seen && rst_n && (cycle + 1 >= free_at)) begin
            e.sum   = model(int'(a), int'(b), eff_s);
            e.ledge = cycle + 1;
            q.push_back(e);
            cur_l   = cycle + 1;
            free_at = cycle + 1 + W + 2;
        end
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n   = 1'b0;
        q.delete();
        cur_l   = -1000;
        free_at = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        rst_n = 1'b0;
        start = 1'b1;
        a_i   = '0;
        b_i   = '0;
`ifdef VIO_SERIAL_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // start already high at release must not launch
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        launch(4'd3, 4'd5, 1'b0, 1);
        repeat (W + 3) @(negedge clk);
        launch(4'd15, 4'd15, 1'b0, 1);
        repeat (W + 3) @(negedge clk);
        launch(4'd6, 4'd9, 1'b0, 20);
        repeat (3) @(negedge clk);
        // retrigger during busy with new operands is ignored
        launch(4'd3, 4'd5, 1'b0, 1);
        launch(4'd1, 4'd1, 1'b0, 1);
        repeat (W + 3) @(negedge clk);
        // reset during busy cycle 2
        launch(4'd7, 4'd8, 1'b0, 1);
        rst_pulse();
        repeat (3) @(negedge clk);
`ifdef VIO_SERIAL_SUB_EN
        launch(4'd5, 4'd7, 1'b1, 1);
        repeat (W + 3) @(negedge clk);
        launch(4'd7, 4'd5, 1'b1, 1);
        repeat (W + 3) @(negedge clk);
        launch(4'd9, 4'd9, 1'b1, 1);
        repeat (W + 3) @(negedge clk);
`endif
        repeat (60) begin
            gap = $urandom_range(0, W + 3);
            repeat (gap) begin
                @(negedge clk);
                a_i = W'($urandom);
                b_i = W'($urandom);
            end
            if ($urandom_range(0, 19) == 0)
                rst_pulse();
            else
                launch(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(1, 3));
        end

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
